// File: rtl/vga_pkg.sv
// Shared raster constants, pixel/state types and the line-base address helper
// for the VGA line fetcher.
package vga_pkg;
    localparam int HACTIVE     = 1280;
    localparam int HTOTAL      = 1600;
    localparam int VACTIVE     = 480;
    localparam int VTOTAL      = 525;
    localparam int LINE_ADDR_W = 19;

    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } fetch_state_t;

    // T*640 as two shifts, recomputed from T each time rather than accumulated
    function automatic logic [LINE_ADDR_W-1:0] line_base(input logic [9:0] t);
        logic [LINE_ADDR_W-1:0] tw;
        tw = LINE_ADDR_W'(t);
        return (tw << 9) + (tw << 7);
    endfunction
endpackage

// File: rtl/line_buffer_ram.sv
// Ping-pong line store: one write port, one registered read port; address MSB
// selects the buffer, the low bits select the column.
module line_buffer_ram #(
    parameter int DEPTH = 1280,
    parameter int DW    = 24,
    parameter int CW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [CW:0]   waddr,
    input  logic [DW-1:0] wdata,
    input  logic [CW:0]   raddr,
    output logic [DW-1:0] rdata
);
    localparam int IW   = $clog2(DEPTH);
    localparam int HALF = DEPTH / 2;

    logic [DW-1:0] mem [0:DEPTH-1];

    // Buffer B starts at HALF so the array stays exactly DEPTH deep
    function automatic logic [IW-1:0] idx(input logic [CW:0] a);
        return a[CW] ? IW'(HALF) + IW'(a[CW-1:0]) : IW'(a[CW-1:0]);
    endfunction

    always_ff @(posedge clk) begin
        if (we)
            mem[idx(waddr)] <= wdata;
        rdata <= mem[idx(raddr)];
    end
endmodule

// File: rtl/vga_line_fetcher.sv
// Prefetches the next display line into a ping-pong buffer while the current
// line is displayed from the other one; drives pixel_color two cycles after raster.
module vga_line_fetcher
    import vga_pkg::*;
#(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int PIX_W    = 24,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  pixel_color,
    output logic              underrun
);
    localparam int CW = $clog2(H_PIXELS + 1);
    localparam logic [CW-1:0] LAST = CW'(H_PIXELS - 1);

    fetch_state_t   state, state_nxt;
    logic [9:0]     tgt;
    logic [CW-1:0]  issue_cnt, ret_cnt;
    logic           trig;
    logic [9:0]     trig_line;
    logic           disp_act, act_q;
    logic [CW:0]    raddr;
    logic [PIX_W-1:0] rdata;

    // Line 0 is fetched during the last blanking line so it gets a full line of lead
    assign trig      = (hcount == '0) &&
                       ((vcount == 10'(VTOTAL - 1)) || (vcount < 10'(V_LINES - 1)));
    assign trig_line = (vcount == 10'(VTOTAL - 1)) ? '0 : vcount + 10'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_addr  = '0;
        case (state)
            IDLE: begin
                if (trig)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                mem_req  = 1'b1;
                mem_addr = ADDR_W'(line_base(tgt)) + ADDR_W'(issue_cnt);
                if (mem_rvalid && ret_cnt == LAST)
                    state_nxt = IDLE;
                else if (mem_gnt && issue_cnt == LAST)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (mem_rvalid && ret_cnt == LAST)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A trigger that lands mid-fetch is dropped; that line keeps stale buffer data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tgt       <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            underrun  <= 1'b0;
        end else if (state == IDLE) begin
            if (trig) begin
                tgt       <= trig_line;
                issue_cnt <= '0;
                ret_cnt   <= '0;
            end
        end else begin
            if (state == ISSUE && mem_gnt)
                issue_cnt <= issue_cnt + 1'b1;
            if (mem_rvalid)
                ret_cnt <= ret_cnt + 1'b1;
            if (trig)
                underrun <= 1'b1;
        end
    end

    // Column is clamped in blanking so the read index stays inside the buffer
    assign disp_act = (hcount < 11'(HACTIVE)) && (vcount < 10'(V_LINES));
    assign raddr    = {vcount[0], disp_act ? CW'(hcount[10:1]) : CW'(0)};

    line_buffer_ram #(
        .DEPTH (2 * H_PIXELS),
        .DW    (PIX_W),
        .CW    (CW)
    ) u_ram (
        .clk   (clk),
        .we    (mem_rvalid && (state != IDLE)),
        .waddr ({tgt[0], ret_cnt}),
        .wdata (mem_rdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q       <= 1'b0;
            pixel_color <= '0;
        end else begin
            act_q       <= disp_act;
            pixel_color <= act_q ? rdata : '0;
        end
    end
endmodule

// File: tb/tb_vga_line_fetcher.sv
// Scoreboard bench: a raster driver and a memory model push expectations;
// independent monitors pop and compare pixels and fetch addresses.
module tb_vga_line_fetcher;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    pixel_t      mem_rdata;
    pixel_t      pixel_color;
    logic        underrun;

    always #5 clk = ~clk;

    vga_line_fetcher dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .hcount      (hcount),
        .vcount      (vcount),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .pixel_color (pixel_color),
        .underrun    (underrun)
    );

    typedef struct {int t; int v; int h; pixel_t val; bit chk;} pix_e;
    typedef struct {int due; pixel_t d;} rsp_e;

    int     cyc = 0, gcount = 0, rcount = 0;
    int     vectors = 0, errors = 0;
    int     gnt_mode = 0, lat_max = 1;
    pixel_t pat = '0;
    int     bufline [2] = '{-1, -1};
    pixel_t bufpat  [2];
    pix_e   pq[$];
    int     exp_addr[$];
    rsp_e   pend[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && mem_req && mem_gnt)
            gcount <= gcount + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Pixel monitor: entry driven at cycle t is visible at cycle t+2
    always @(negedge clk) begin
        if (reset_n) begin
            while (pq.size() > 0 && pq[0].t + 2 <= cyc) begin
                pix_e e;
                e = pq.pop_front();
                if (e.t + 2 == cyc && e.chk) begin
                    vectors++;
                    if (pixel_color !== e.val) begin
                        errors++;
                        $display("FAIL pixel v=%0d h=%0d: got %h expected %h",
                                 e.v, e.h, pixel_color, e.val);
                    end
                end
            end
        end
    end

    // Memory model: grant policy, in-order responses, address scoreboard
    initial begin
        int     lat, due, last_due, ea;
        bit     g, prev_wait;
        logic [18:0] prev_addr;
        rsp_e   r;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        last_due = 0; prev_wait = 0; prev_addr = '0;
        forever begin
            @(posedge clk); #2;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend[0].d;
                void'(pend.pop_front());
                rcount++;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 24'($urandom);
            end
            if (prev_wait && reset_n)
                check("addr_hold", {mem_req, mem_addr}, {1'b1, prev_addr});
            if (mem_req && exp_addr.size() == 0) begin
                vectors++; errors++;
                if (errors < 40)
                    $display("FAIL spurious_req: got req addr %0d expected no request", mem_addr);
            end
            case (gnt_mode)
                0:       g = 1'b1;
                1:       g = $urandom_range(1, 0) == 1;
                default: g = (cyc % 4) == 0;
            endcase
            mem_gnt = g;
            if (mem_req && g && exp_addr.size() > 0) begin
                ea = exp_addr.pop_front();
                check("fetch_addr", 32'(mem_addr), ea);
                lat = $urandom_range(lat_max, 1);
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                r.due = due;
                r.d   = 24'(mem_addr) ^ pat;
                pend.push_back(r);
            end
            prev_wait = reset_n && mem_req && !g;
            prev_addr = mem_addr;
        end
    end

    // Raster driver; the model tracks which line each buffer holds
    task automatic drive(input int v, input int h, input bit fetch_ok);
        int   t, b;
        bit   act, known;
        pix_e e;
        @(posedge clk); #1;
        hcount = 11'(h);
        vcount = 10'(v);
        if (h == 0 && (v == 524 || v < 479) && fetch_ok) begin
            t = (v == 524) ? 0 : v + 1;
            for (int x = 0; x < 640; x++) exp_addr.push_back(t * 640 + x);
            bufline[t % 2] = t;
            bufpat[t % 2]  = pat;
        end
        act   = (h < 1280) && (v < 480);
        b     = v % 2;
        known = bufline[b] == v;
        e.t = cyc; e.v = v; e.h = h;
        e.chk = !act || known;
        e.val = (act && known) ? (24'(v * 640 + h / 2) ^ bufpat[b]) : '0;
        pq.push_back(e);
    endtask

    task automatic run_line(input int v, input int hs, input bit fetch_ok);
        for (int h = hs; h < 1600; h++) drive(v, h, fetch_ok);
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL timeout: simulation exceeded cycle budget");
        $fatal(1, "timeout");
    end

    initial begin
        int r0, g0, n;
        hcount = 11'd777; vcount = 10'd100; reset_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_pixel", pixel_color, 0);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_underrun", underrun, 0);
        reset_n = 1'b1;
        pq.delete();
        run_line(200, 1, 1);

        // Ideal memory, data equals address
        gnt_mode = 0; lat_max = 1; pat = '0;
        run_line(524, 0, 1);
        run_line(0, 0, 1);
        run_line(1, 0, 1);
        run_line(478, 0, 1);
        run_line(479, 0, 1);
        run_line(500, 0, 1);
        check("ideal_underrun", underrun, 0);

        // Random backpressure and latency
        gnt_mode = 1; lat_max = 8; pat = 24'($urandom);
        run_line(524, 0, 1);
        for (int v = 0; v < 5; v++) run_line(v, 0, 1);
        check("random_underrun", underrun, 0);

        // Slow memory: the fetch overruns into the next trigger
        gnt_mode = 2; lat_max = 4; pat = 24'($urandom);
        r0 = rcount;
        run_line(10, 0, 1);
        run_line(11, 0, 0);
        check("slow_underrun_set", underrun, 1);
        run_line(11, 1, 1);
        check("slow_underrun_sticky", underrun, 1);
        check("slow_returns", rcount - r0, 640);
        check("slow_all_issued", exp_addr.size(), 0);

        // Reset in the middle of ISSUE
        gnt_mode = 0; lat_max = 8; pat = 24'($urandom);
        drive(20, 0, 1);
        g0 = gcount - (mem_req && mem_gnt ? 0 : 0);
        g0 = gcount;
        n = 0;
        while (gcount - g0 < 100 && n < 1500) begin
            drive(20, 1 + n, 1);
            n++;
        end
        check("mid_issue_reached", gcount - g0, 100);
        check("pre_reset_underrun", underrun, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_req", mem_req, 0);
        check("midrst_addr", mem_addr, 0);
        exp_addr.delete();
        bufline[1] = -1;
        pq.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        pq.delete();
        check("midrst_underrun", underrun, 0);
        run_line(20, n + 5, 1);
        run_line(21, 0, 1);
        run_line(22, 1, 1);
        check("final_underrun", underrun, 0);
        check("final_all_issued", exp_addr.size(), 0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
